// File: rtl/event_encoder_8to3_pkg.sv
// Shared constants and helpers for the 8-to-3 event encoder slice.
package event_encoder_8to3_pkg;

  // Number of request lines, width of the encoded index, and the
  // widths of the pending vector and its population count.
  localparam int EE_N      = 8;
  localparam int EE_CODE_W = 3;
  localparam int EE_PEND_W = EE_N;
  localparam int EE_CNT_W  = 4;

  // Population count of an 8-bit pending vector (result 0..8).
  function automatic logic [EE_CNT_W-1:0] popcount8(input logic [EE_PEND_W-1:0] v);
    logic [EE_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < EE_PEND_W; i++) begin
      cnt = cnt + EE_CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // One-hot mask with only bit idx set.
  function automatic logic [EE_PEND_W-1:0] onehot8(input logic [EE_CODE_W-1:0] idx);
    logic [EE_PEND_W-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: finds the first set bit of pend
// starting at ptr and searching upward, wrapping from 7 back to 0.
module rr_pick8
  import event_encoder_8to3_pkg::*;
(
  input  logic [EE_PEND_W-1:0] pend,
  input  logic [EE_CODE_W-1:0] ptr,
  output logic                 any,
  output logic [EE_CODE_W-1:0] idx
);

  // Walk the eight positions in priority order; the first hit wins.
  always_comb begin
    logic [EE_CODE_W-1:0] pos;
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = 0; i < EE_PEND_W; i++) begin
      pos = ptr + EE_CODE_W'(i);
      if (!any && pend[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/event_encoder_8to3.sv
// Event encoder: captures one-hot request pulses from the decoder stage
// into a pending register and serves them one at a time, round-robin,
// through a single valid/ready output slot. Lost requests raise a
// sticky overflow flag.
module event_encoder_8to3
  import event_encoder_8to3_pkg::*;
#(
  parameter int N      = EE_N,
  parameter int CODE_W = EE_CODE_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              y1,
  input  logic              y2,
  input  logic              y3,
  input  logic              y4,
  input  logic              y5,
  input  logic              y6,
  input  logic              y7,
  input  logic              y8,
  input  logic              out_ready,
  input  logic              clr_ovf,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [3:0]        pend_cnt,
  output logic              ovf
);

  // Request vector: bit k-1 carries line yk, so the bit index is the code.
  logic [N-1:0]      req;
  logic [N-1:0]      pend;
  logic [CODE_W-1:0] ptr;

  logic              pick_any;
  logic [CODE_W-1:0] pick_idx;
  logic              slot_free;
  logic              load;
  logic [N-1:0]      load_mask;
  logic [N-1:0]      pend_nxt;
  logic              ovf_hit;

  assign req = {y8, y7, y6, y5, y4, y3, y2, y1};

  rr_pick8 u_pick (
    .pend (pend),
    .ptr  (ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Decide whether the slot loads this edge, which pending bit it takes,
  // and whether any incoming request collides with a bit that stays
  // pending. A request on the bit being loaded re-arms it (set wins).
  always_comb begin
    slot_free = !out_valid || out_ready;
    load      = slot_free && pick_any;
    load_mask = load ? onehot8(pick_idx) : '0;
    pend_nxt  = (pend & ~load_mask) | req;
    ovf_hit   = |(req & pend & ~load_mask);
  end

  // All state: pending bits, pointer, output slot, count and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      pend_cnt  <= '0;
      ovf       <= 1'b0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= popcount8(pend_nxt);
      if (load) begin
        out_valid <= 1'b1;
        out_code  <= pick_idx;
        ptr       <= pick_idx + CODE_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovf_hit) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Self-checking bench for event_encoder_8to3: directed scenarios followed
// by random traffic, checked against a behavioural model of the pending
// set, round-robin pointer and output slot. Accepted codes flow through a
// scoreboard queue popped by an independent monitor.
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       y1, y2, y3, y4, y5, y6, y7, y8;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid;
  logic [2:0] out_code;
  logic [3:0] pend_cnt;
  logic       ovf;

  int vectors    = 0;
  int miscompares = 0;
  int exp_q[$];
  bit monitor_on = 1'b0;

  // Reference model state.
  bit m_pend[8];
  int m_ptr;
  bit m_valid;
  int m_code;
  bit m_ovf;

  event_encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .y6        (y6),
    .y7        (y7),
    .y8        (y8),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_code  (out_code),
    .pend_cnt  (pend_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int k = 0; k < 8; k++) c += m_pend[k];
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_code = 0; m_ovf = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs seen on it.
  task automatic model_step(input logic [7:0] r, input bit rdy, input bit clr, input bit rs);
    int loaded;
    bit lost;
    if (rs) begin
      model_reset();
      return;
    end
    loaded = -1;
    if (!m_valid || rdy) begin
      for (int i = 0; i < 8; i++) begin
        if (loaded < 0 && m_pend[(m_ptr + i) % 8]) loaded = (m_ptr + i) % 8;
      end
    end
    lost = 1'b0;
    for (int k = 0; k < 8; k++) if (r[k] && m_pend[k] && k != loaded) lost = 1'b1;
    if (loaded >= 0) m_pend[loaded] = 1'b0;
    for (int k = 0; k < 8; k++) if (r[k]) m_pend[k] = 1'b1;
    if (loaded >= 0) begin
      m_valid = 1'b1; m_code = loaded; m_ptr = (loaded + 1) % 8;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // Compare what the DUT presents against the model's current state.
  task automatic check_output();
    compare("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) compare("out_code", 32'(out_code), 32'(m_code));
    compare("pend_cnt", 32'(pend_cnt), 32'(model_count()));
    compare("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs (entered just after a rising edge),
  // record any expected accept, check, then advance the model.
  task automatic apply_stimulus(input logic [7:0] r, input bit rdy, input bit clr, input bit rs);
    {y8, y7, y6, y5, y4, y3, y2, y1} = r;
    out_ready = rdy;
    clr_ovf   = clr;
    rst       = rs;
    if (!rs && m_valid && rdy) exp_q.push_back(m_code);
    @(negedge clk);
    check_output();
    @(posedge clk);
    model_step(r, rdy, clr, rs);
    #1;
  endtask

  // Monitor: every accepted output must match the next expected code.
  always @(negedge clk) begin
    if (monitor_on && rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept_unexpected: got code %0d, expected no accept", out_code);
      end else begin
        compare("accept_code", 32'(out_code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    {y8, y7, y6, y5, y4, y3, y2, y1} = 8'h00;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    monitor_on = 1'b1;

    $display("[TB] reset state");
    apply_stimulus(8'h00, 1'b1, 1'b0, 1'b1);

    $display("[TB] single request on y3");
    apply_stimulus(8'h04, 1'b1, 1'b0, 1'b0);
    repeat (4) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] round-robin y1,y5,y8 then y1,y2");
    apply_stimulus(8'h91, 1'b1, 1'b0, 1'b0);
    repeat (5) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h03, 1'b1, 1'b0, 1'b0);
    repeat (4) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure on y2");
    apply_stimulus(8'h02, 1'b0, 1'b0, 1'b0);
    repeat (12) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] overflow on y4");
    repeat (4) apply_stimulus(8'h08, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'h08, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
    repeat (4) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] all eight then reset mid-drain");
    apply_stimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (3) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h20, 1'b1, 1'b0, 1'b1);
    repeat (6) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = ($urandom_range(0, 7) == 0);
      apply_stimulus(r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 199) == 0));
    end

    repeat (12) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
    compare("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
